conv_mac_tree: RTL and testbench

//  Pipelined multiply/adder-tree stage that consumes the flat window/filter buses and start strobe from

---
 rtl/conv_mac_tree_pkg.sv | 26 ++
 rtl/conv_add_level.sv | 37 +++
 rtl/conv_mac_tree.sv | 141 ++++++++++++++
 tb/tb_conv_mac_tree.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_tree_pkg.sv
// Shared sizing helpers for the convolution MAC tree: lane width, lane count,
// adder-tree depth, end-to-end latency and per-level operand counts.
package conv_mac_tree_pkg;

  localparam int LANE_W = 32;

  function automatic int k2_of(input int k);
    return k * k;
  endfunction

  function automatic int tree_depth_of(input int k);
    return $clog2(k * k);
  endfunction

  function automatic int latency_of(input int k);
    return 2 + tree_depth_of(k) + 1;
  endfunction

  // Operand count left after lvl pairwise levels (odd operand passes through).
  function automatic int level_n(input int n, input int lvl);
    int r = n;
    for (int i = 0; i < lvl; i++) r = (r + 1) / 2;
    return r;
  endfunction

endpackage

// File: rtl/conv_add_level.sv
// One registered pairwise adder level: N lanes in, ceil(N/2) lanes out, odd lane passes through.
// Latency 1 clock, valid forwarded alongside data, no backpressure.
module conv_add_level
  import conv_mac_tree_pkg::*;
#(
  parameter int N = 9,
  parameter int W = 32,
  localparam int M = level_n(N, 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [N*W-1:0] in_dat,
  output logic         out_vld,
  output logic [M*W-1:0] out_dat
);

  logic [M*W-1:0] sum;

  for (genvar j = 0; j < M; j++) begin : g_pair
    if (2 * j + 1 < N) begin : g_add
      assign sum[j*W +: W] = in_dat[2*j*W +: W] + in_dat[(2*j+1)*W +: W];
    end else begin : g_pass
      assign sum[j*W +: W] = in_dat[2*j*W +: W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_vld <= 1'b0;
    else     out_vld <= in_vld;
  end

  always_ff @(posedge clk) begin
    out_dat <= sum;
  end

endmodule

// File: rtl/conv_mac_tree.sv
// Per-channel convolution MAC: capture, K2 signed multiplies, registered adder tree, optional accumulate.
// Latency 2+clog2(K2)+1 clocks (7 for K=3); accepts one window per clock, no backpressure.
module conv_mac_tree
  import conv_mac_tree_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int OP_WIDTH    = 16,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                                     Clk,
  input  logic                                     Rst,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*LANE_W-1:0] multiplier_input,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*LANE_W-1:0] multiplicand_input,
  input  logic [KERNEL_SIZE*KERNEL_SIZE-1:0]        mStart,
  input  logic                                     direct,
  input  logic                                     acc_clear,
  output logic [ACC_WIDTH-1:0]                     finalAccumulate,
  output logic                                     finalReady,
  output logic                                     busy
);

  localparam int K2         = k2_of(KERNEL_SIZE);
  localparam int TREE_DEPTH = tree_depth_of(KERNEL_SIZE);
  localparam int HI_W       = LANE_W - OP_WIDTH;
  localparam int PW         = 2 * OP_WIDTH;

  logic                   accept;
  logic                   s0_vld;
  logic                   s1_vld;
  logic [K2*ACC_WIDTH-1:0] prod_bus;
  logic [TREE_DEPTH-1:0]  lvl_vld;
  logic [TREE_DEPTH+1:0]  dir_q;
  logic                   tree_vld;
  logic                   tree_dir;
  logic [ACC_WIDTH-1:0]   tree_sum;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   acc_base;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic [2*K2*HI_W-1:0]   lane_hi_unused;

  assign accept = &mStart;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s0_vld <= 1'b0;
      s1_vld <= 1'b0;
    end else begin
      s0_vld <= accept;
      s1_vld <= s0_vld;
    end
  end

  // The direct flag rides alongside its window so mixed-mode bursts stay aligned.
  always_ff @(posedge Clk) begin
    dir_q <= {dir_q[TREE_DEPTH:0], direct};
  end
  assign tree_dir = dir_q[TREE_DEPTH+1];

  for (genvar i = 0; i < K2; i++) begin : g_lane
    logic [OP_WIDTH-1:0]  win_q;
    logic [OP_WIDTH-1:0]  tap_q;
    logic signed [PW-1:0] prod;
    logic [ACC_WIDTH-1:0] prod_q;

    always_ff @(posedge Clk) begin
      if (accept) begin
        win_q <= multiplier_input[i*LANE_W +: OP_WIDTH];
        tap_q <= multiplicand_input[i*LANE_W +: OP_WIDTH];
      end
    end

    assign prod = PW'($signed(win_q)) * PW'($signed(tap_q));

    always_ff @(posedge Clk) begin
      prod_q <= ACC_WIDTH'(prod);
    end

    assign prod_bus[i*ACC_WIDTH +: ACC_WIDTH] = prod_q;
    assign lane_hi_unused[2*i*HI_W +: 2*HI_W] =
      {multiplier_input[i*LANE_W+OP_WIDTH +: HI_W], multiplicand_input[i*LANE_W+OP_WIDTH +: HI_W]};
  end

  for (genvar l = 0; l < TREE_DEPTH; l++) begin : g_lvl
    localparam int NI = level_n(K2, l);
    localparam int NO = level_n(K2, l + 1);
    logic [NI*ACC_WIDTH-1:0] din;
    logic                    dvld;
    logic [NO*ACC_WIDTH-1:0] dout;
    logic                    ovld;

    if (l == 0) begin : g_first
      assign din  = prod_bus;
      assign dvld = s1_vld;
    end else begin : g_next
      assign din  = g_lvl[l-1].dout;
      assign dvld = g_lvl[l-1].ovld;
    end

    conv_add_level #(.N(NI), .W(ACC_WIDTH)) u_add (
      .clk    (Clk),
      .rst    (Rst),
      .in_vld (dvld),
      .in_dat (din),
      .out_vld(ovld),
      .out_dat(dout)
    );

    assign lvl_vld[l] = ovld;

    if (l == TREE_DEPTH - 1) begin : g_root
      assign tree_sum = dout;
      assign tree_vld = ovld;
    end
  end

  // A clear coincident with a running result wins first, so the result restarts the sum.
  always_comb begin
    acc_base = acc_clear ? '0 : acc_q;
    acc_next = acc_base + tree_sum;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      finalReady      <= 1'b0;
      finalAccumulate <= '0;
      acc_q           <= '0;
    end else begin
      finalReady <= tree_vld;
      if (tree_vld && !tree_dir) begin
        acc_q           <= acc_next;
        finalAccumulate <= acc_next;
      end else begin
        if (tree_vld)  finalAccumulate <= tree_sum;
        if (acc_clear) acc_q <= '0;
      end
    end
  end

  assign busy = s0_vld | s1_vld | (|lvl_vld) | finalReady;

endmodule

// File: tb/tb_conv_mac_tree.sv
// Directed bench for conv_mac_tree (K=3): latency, sums, back-to-back flow,
// accumulation/clear ordering, partial start, mid-flight reset and wrap.
module tb_conv_mac_tree;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [287:0]  multiplier_input = '0;
  logic [287:0]  multiplicand_input = '0;
  logic [8:0]    mStart = '0;
  logic          direct = 1'b0;
  logic          acc_clear = 1'b0;
  logic [31:0]   finalAccumulate;
  logic          finalReady;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] win [9];
  logic [15:0] tap [9];

  conv_mac_tree #(.KERNEL_SIZE(3), .OP_WIDTH(16), .ACC_WIDTH(32)) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .multiplier_input  (multiplier_input),
    .multiplicand_input(multiplicand_input),
    .mStart            (mStart),
    .direct            (direct),
    .acc_clear         (acc_clear),
    .finalAccumulate   (finalAccumulate),
    .finalReady        (finalReady),
    .busy              (busy)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Upper lane halves carry junk that the DUT must ignore.
  task automatic load_bus();
    for (int i = 0; i < 9; i++) begin
      multiplier_input[i*32 +: 32]   = {16'hDEAD, win[i]};
      multiplicand_input[i*32 +: 32] = {16'hBEEF, tap[i]};
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < 9; i++) begin
      tap[i] = (i == 8) ? 16'd1 : 16'd0;
      win[i] = 16'd0;
    end
  endtask

  // Accept one window; lat counts edges from the accepting edge (=1) to finalReady.
  task automatic send_and_time(output int lat);
    load_bus();
    mStart = '1;
    tick();
    mStart = '0;
    lat = 1;
    while (finalReady !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    checks++;
    if (finalReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", finalReady); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (finalAccumulate !== 32'h0) begin errors++; $display("FAIL reset_acc: got %h expected 00000000", finalAccumulate); end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    int lat;
    set_identity();
    for (int i = 0; i < 9; i++) win[i] = 16'(i);
    direct = 1'b1;
    send_and_time(lat);
    checks++;
    if (lat != 7) begin errors++; $display("FAIL identity_latency: got %0d expected 7", lat); end
    checks++;
    if (finalAccumulate !== 32'd8) begin errors++; $display("FAIL identity_sum: got %h expected 00000008", finalAccumulate); end
    tick();
    checks++;
    if (finalReady !== 1'b0) begin errors++; $display("FAIL identity_pulse_width: got %b expected 0", finalReady); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL identity_busy_drop: got %b expected 0", busy); end
    checks++;
    if (finalAccumulate !== 32'd8) begin errors++; $display("FAIL identity_hold: got %h expected 00000008", finalAccumulate); end
  endtask

  task automatic test_sums();
    int lat;
    direct = 1'b1;
    for (int i = 0; i < 9; i++) begin tap[i] = 16'd1; win[i] = 16'(i + 1); end
    send_and_time(lat);
    checks++;
    if (lat != 7 || finalAccumulate !== 32'd45)
      begin errors++; $display("FAIL sum_ones: got %h lat %0d expected 0000002d lat 7", finalAccumulate, lat); end
    tick();
    for (int i = 0; i < 9; i++) begin tap[i] = 16'hFFFF; win[i] = 16'd100; end
    send_and_time(lat);
    checks++;
    if (lat != 7 || finalAccumulate !== 32'hFFFFFC7C)
      begin errors++; $display("FAIL sum_negative: got %h lat %0d expected fffffc7c lat 7", finalAccumulate, lat); end
    tick();
  endtask

  task automatic test_back_to_back();
    int   ev [3];
    logic exp_rdy;
    ev = '{8, 17, 26};
    set_identity();
    direct = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      if (e <= 3) begin win[8] = 16'(ev[e-1]); load_bus(); mStart = '1; end
      else mStart = '0;
      tick();
      exp_rdy = (e >= 7 && e <= 9);
      checks++;
      if (finalReady !== exp_rdy) begin errors++; $display("FAIL b2b_ready_e%0d: got %b expected %b", e, finalReady, exp_rdy); end
      if (exp_rdy) begin
        checks++;
        if (finalAccumulate !== 32'(ev[e-7]))
          begin errors++; $display("FAIL b2b_value_e%0d: got %0d expected %0d", e, finalAccumulate, ev[e-7]); end
      end
      checks++;
      if (busy !== (e <= 9)) begin errors++; $display("FAIL b2b_busy_e%0d: got %b expected %b", e, busy, (e <= 9)); end
    end
  endtask

  // Round 0: plain accumulation; round 1: clear lands on the 3rd result;
  // round 2: a direct window between running windows leaves the accumulator alone.
  task automatic test_accumulate();
    int   sums [3][3];
    int   exps [3][3];
    int   nw;
    logic exp_rdy;
    sums = '{'{10, 20, 30}, '{10, 20, 30}, '{5, 1, 0}};
    exps = '{'{10, 30, 60}, '{10, 30, 30}, '{5, 31, 0}};
    set_identity();
    for (int r = 0; r < 3; r++) begin
      nw = (r == 2) ? 2 : 3;
      if (r < 2) begin acc_clear = 1'b1; tick(); acc_clear = 1'b0; end
      for (int e = 1; e <= 10; e++) begin
        if (e <= nw) begin
          win[8] = 16'(sums[r][e-1]);
          load_bus();
          direct = (r == 2 && e == 1);
          mStart = '1;
        end else begin
          mStart = '0;
          direct = 1'b0;
        end
        acc_clear = (r == 1 && e == 9);
        tick();
        acc_clear = 1'b0;
        exp_rdy = (e >= 7 && e <= 6 + nw);
        checks++;
        if (finalReady !== exp_rdy) begin errors++; $display("FAIL acc_ready_r%0d_e%0d: got %b expected %b", r, e, finalReady, exp_rdy); end
        if (exp_rdy) begin
          checks++;
          if (finalAccumulate !== 32'(exps[r][e-7]))
            begin errors++; $display("FAIL acc_value_r%0d_e%0d: got %0d expected %0d", r, e, finalAccumulate, exps[r][e-7]); end
        end
      end
    end
  endtask

  task automatic test_partial_and_reset();
    int seen;
    int lat;
    set_identity();
    win[8] = 16'd8;
    direct = 1'b1;
    load_bus();
    mStart = 9'h1FE;
    seen = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      mStart = '0;
      if (finalReady === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL partial_start: got %0d active cycles expected 0", seen); end

    mStart = '1;
    tick();
    mStart = '0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL inflight_busy: got %b expected 1", busy); end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || finalReady !== 1'b0 || finalAccumulate !== 32'h0)
      begin errors++; $display("FAIL midreset_outputs: got busy %b ready %b acc %h expected 0 0 00000000", busy, finalReady, finalAccumulate); end
    seen = 0;
    for (int e = 0; e < 10; e++) begin
      tick();
      if (finalReady === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_discard: got %0d active cycles expected 0", seen); end

    direct = 1'b0;
    win[8] = 16'd7;
    send_and_time(lat);
    checks++;
    if (lat != 7 || finalAccumulate !== 32'd7)
      begin errors++; $display("FAIL midreset_acc_zero: got %0d lat %0d expected 7 lat 7", finalAccumulate, lat); end
    tick();
  endtask

  task automatic test_wrap();
    int lat;
    direct = 1'b1;
    for (int i = 0; i < 9; i++) begin tap[i] = 16'h7FFF; win[i] = 16'h7FFF; end
    send_and_time(lat);
    checks++;
    if (lat != 7 || finalAccumulate !== 32'h3FF70009)
      begin errors++; $display("FAIL wrap: got %h lat %0d expected 3ff70009 lat 7", finalAccumulate, lat); end
    tick();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_sums();
    test_back_to_back();
    test_accumulate();
    test_partial_and_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
